// File: rtl/vga_pkg.sv
// Shared video definitions: default bus widths, 800x600 timing constants and the layer config record.
package vga_pkg;

  localparam int CW_DEFAULT    = 11;
  localparam int RGB_W_DEFAULT = 12;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int H_TOTAL  = 1056;
  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 23;
  localparam int V_TOTAL  = 628;

  typedef struct packed {
    logic                     en;
    logic [CW_DEFAULT-1:0]    x;
    logic [CW_DEFAULT-1:0]    y;
    logic [CW_DEFAULT-1:0]    w;
    logic [CW_DEFAULT-1:0]    h;
    logic [RGB_W_DEFAULT-1:0] rgb;
  } layer_cfg_t;

endpackage

// File: rtl/layer_hit.sv
// One rectangle layer: shadow/active config pair swapped on commit, plus a combinational hit test.
// Config writes never stall; the hit output reflects the active set only.
module layer_hit import vga_pkg::*; #(
  parameter int CW    = CW_DEFAULT,
  parameter int RGB_W = RGB_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic             commit_i,
  input  logic             en_i,
  input  logic [CW-1:0]    x_i,
  input  logic [CW-1:0]    y_i,
  input  logic [CW-1:0]    w_i,
  input  logic [CW-1:0]    h_i,
  input  logic [RGB_W-1:0] rgb_i,
  input  logic [CW-1:0]    hcount_i,
  input  logic [CW-1:0]    vcount_i,
  output logic             hit_o,
  output logic [RGB_W-1:0] rgb_o
);

  localparam int SW = 1 + 4*CW + RGB_W;

  logic [SW-1:0] shadow_q, shadow_d;
  logic [SW-1:0] active_q, active_d;
  logic          a_en;
  logic [CW-1:0] a_x, a_y, a_w, a_h;
  logic [CW:0]   x_end, y_end;

  // Commit copies the shadow value held before any same-cycle write.
  assign shadow_d = we_i ? {en_i, x_i, y_i, w_i, h_i, rgb_i} : shadow_q;
  assign active_d = commit_i ? shadow_q : active_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign {a_en, a_x, a_y, a_w, a_h, rgb_o} = active_q;

  assign x_end = {1'b0, a_x} + {1'b0, a_w};
  assign y_end = {1'b0, a_y} + {1'b0, a_h};

  assign hit_o = a_en
              && (hcount_i >= a_x) && ({1'b0, hcount_i} < x_end)
              && (vcount_i >= a_y) && ({1'b0, vcount_i} < y_end);

endmodule

// File: rtl/vga_layer_mixer.sv
// Composites N_LAYERS fixed-priority rectangles over the pixel stream, 2-cycle latency on every output.
// No backpressure; geometry changes are committed on the rising edge of vblnk_in.
module vga_layer_mixer import vga_pkg::*; #(
  parameter int N_LAYERS = 4,
  parameter int CW       = CW_DEFAULT,
  parameter int RGB_W    = RGB_W_DEFAULT,
  localparam int LW      = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [CW-1:0]    hcount_in,
  input  logic [CW-1:0]    vcount_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic [RGB_W-1:0] rgb_in,
  input  logic             cfg_we,
  input  logic [LW-1:0]    cfg_layer,
  input  logic             cfg_en,
  input  logic [CW-1:0]    cfg_x,
  input  logic [CW-1:0]    cfg_y,
  input  logic [CW-1:0]    cfg_w,
  input  logic [CW-1:0]    cfg_h,
  input  logic [RGB_W-1:0] cfg_rgb,
  output logic [CW-1:0]    hcount_out,
  output logic [CW-1:0]    vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic [RGB_W-1:0] rgb_out,
  output logic             commit_pending
);

  logic                vblnk_q;
  logic                commit;
  logic                wr_ok;
  logic                pending_q, pending_d;
  logic [N_LAYERS-1:0] hit_vec;
  logic [RGB_W-1:0]    lay_rgb [N_LAYERS];

  logic [N_LAYERS-1:0] s1_hit_q;
  logic [CW-1:0]       s1_h_q, s1_v_q;
  logic                s1_hs_q, s1_vs_q, s1_hb_q, s1_vb_q;
  logic [RGB_W-1:0]    s1_rgb_q;

  logic [CW-1:0]       s2_h_q, s2_v_q;
  logic                s2_hs_q, s2_vs_q, s2_hb_q, s2_vb_q;
  logic [RGB_W-1:0]    s2_rgb_q, s2_rgb_d;
  logic                sel_hit;
  logic [RGB_W-1:0]    sel_rgb;

  assign commit    = vblnk_in && !vblnk_q;
  assign wr_ok     = cfg_we && (32'(cfg_layer) < N_LAYERS);
  assign pending_d = wr_ok ? 1'b1 : (commit ? 1'b0 : pending_q);

  for (genvar k = 0; k < N_LAYERS; k++) begin : g_layer
    layer_hit #(.CW(CW), .RGB_W(RGB_W)) u_layer (
      .clk_i    (pclk),
      .rst_i    (rst),
      .we_i     (wr_ok && (cfg_layer == LW'(k))),
      .commit_i (commit),
      .en_i     (cfg_en),
      .x_i      (cfg_x),
      .y_i      (cfg_y),
      .w_i      (cfg_w),
      .h_i      (cfg_h),
      .rgb_i    (cfg_rgb),
      .hcount_i (hcount_in),
      .vcount_i (vcount_in),
      .hit_o    (hit_vec[k]),
      .rgb_o    (lay_rgb[k])
    );
  end

  // Scan from lowest priority up so layer 0 wins the final assignment.
  always_comb begin
    sel_hit = 1'b0;
    sel_rgb = '0;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (s1_hit_q[k]) begin
        sel_hit = 1'b1;
        sel_rgb = lay_rgb[k];
      end
    end
    s2_rgb_d = (s1_hb_q || s1_vb_q) ? '0 : (sel_hit ? sel_rgb : s1_rgb_q);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_q   <= 1'b0;
      pending_q <= 1'b0;
      s1_hit_q  <= '0;
      s1_h_q    <= '0;
      s1_v_q    <= '0;
      s1_hs_q   <= 1'b0;
      s1_vs_q   <= 1'b0;
      s1_hb_q   <= 1'b0;
      s1_vb_q   <= 1'b0;
      s1_rgb_q  <= '0;
      s2_h_q    <= '0;
      s2_v_q    <= '0;
      s2_hs_q   <= 1'b0;
      s2_vs_q   <= 1'b0;
      s2_hb_q   <= 1'b0;
      s2_vb_q   <= 1'b0;
      s2_rgb_q  <= '0;
    end else begin
      vblnk_q   <= vblnk_in;
      pending_q <= pending_d;
      s1_hit_q  <= hit_vec;
      s1_h_q    <= hcount_in;
      s1_v_q    <= vcount_in;
      s1_hs_q   <= hsync_in;
      s1_vs_q   <= vsync_in;
      s1_hb_q   <= hblnk_in;
      s1_vb_q   <= vblnk_in;
      s1_rgb_q  <= rgb_in;
      s2_h_q    <= s1_h_q;
      s2_v_q    <= s1_v_q;
      s2_hs_q   <= s1_hs_q;
      s2_vs_q   <= s1_vs_q;
      s2_hb_q   <= s1_hb_q;
      s2_vb_q   <= s1_vb_q;
      s2_rgb_q  <= s2_rgb_d;
    end
  end

  assign hcount_out     = s2_h_q;
  assign vcount_out     = s2_v_q;
  assign hsync_out      = s2_hs_q;
  assign vsync_out      = s2_vs_q;
  assign hblnk_out      = s2_hb_q;
  assign vblnk_out      = s2_vb_q;
  assign rgb_out        = s2_rgb_q;
  assign commit_pending = pending_q;

endmodule
